// File: rtl/img_axis_crop.sv
// Video crop stage: forwards pixels inside a programmable window of an AXI-stream
// frame (tuser = SOF, tlast = EOL, no backpressure), regenerating SOF/EOL and flagging malformed frames.
module img_axis_crop #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned CW         = 12
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [CW-1:0]         x_start,
    input  logic [CW-1:0]         y_start,
    input  logic [CW-1:0]         crop_w,
    input  logic [CW-1:0]         crop_h,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_sof,
    output logic                  err_line,
    output logic                  frame_done
);

    localparam int unsigned XW = CW + 1;

    typedef enum logic [0:0] {WAIT_SOF, IN_FRAME} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   col, row, col_nx, row_nx;
    logic [CW-1:0]   x_q, y_q, w_q, h_q;
    logic [CW-1:0]   cfg_x, cfg_y, cfg_w, cfg_h;
    logic [CW-1:0]   cur_col, cur_row;
    logic [XW-1:0]   x_sum, y_sum, x_end, y_end;
    logic            sof_beat, active;
    logic            at_last_col, line_end, last_row;
    logic            x_in, y_in;
    logic            inside_c, out_user_c, out_last_c;
    logic            err_sof_c, err_line_c, frame_done_c;

    // An SOF beat uses the live config and restarts the coordinates at (0,0)
    assign sof_beat = s_axis_tvalid & s_axis_tuser;
    assign active   = s_axis_tvalid & ((state == IN_FRAME) | s_axis_tuser);
    assign cfg_x    = sof_beat ? x_start : x_q;
    assign cfg_y    = sof_beat ? y_start : y_q;
    assign cfg_w    = sof_beat ? crop_w  : w_q;
    assign cfg_h    = sof_beat ? crop_h  : h_q;
    assign cur_col  = sof_beat ? '0 : col;
    assign cur_row  = sof_beat ? '0 : row;

    // Window end clipped to the image, computed one bit wider so it cannot wrap
    assign x_sum = XW'(cfg_x) + XW'(cfg_w);
    assign y_sum = XW'(cfg_y) + XW'(cfg_h);
    assign x_end = (x_sum > XW'(IMG_WIDTH))  ? XW'(IMG_WIDTH)  : x_sum;
    assign y_end = (y_sum > XW'(IMG_HEIGHT)) ? XW'(IMG_HEIGHT) : y_sum;

    assign x_in     = (cur_col >= cfg_x) && (XW'(cur_col) < x_end);
    assign y_in     = (cur_row >= cfg_y) && (XW'(cur_row) < y_end);
    assign inside_c = active & x_in & y_in;

    assign out_user_c = inside_c && (cur_col == cfg_x) && (cur_row == cfg_y);
    assign out_last_c = inside_c && (XW'(cur_col) == (x_end - XW'(1)));

    assign at_last_col  = (cur_col == CW'(IMG_WIDTH - 1));
    assign line_end     = s_axis_tlast | at_last_col;
    assign last_row     = (cur_row == CW'(IMG_HEIGHT - 1));
    assign err_line_c   = active & (s_axis_tlast != at_last_col);
    assign err_sof_c    = sof_beat & (state == IN_FRAME);
    assign frame_done_c = active & line_end & last_row;

    // Next-state and coordinate counters
    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        if (active) begin
            state_nx = IN_FRAME;
            if (line_end) begin
                col_nx = '0;
                if (last_row) begin
                    row_nx   = '0;
                    state_nx = WAIT_SOF;
                end else begin
                    row_nx = cur_row + CW'(1);
                end
            end else begin
                col_nx = cur_col + CW'(1);
                row_nx = cur_row;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state <= WAIT_SOF;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            row   <= row_nx;
        end
    end

    // Window config is captured only on SOF beats
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else if (sof_beat) begin
            x_q <= x_start;
            y_q <= y_start;
            w_q <= crop_w;
            h_q <= crop_h;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_sof       <= 1'b0;
            err_line      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            if (inside_c) begin
                m_axis_tdata <= s_axis_tdata;
            end
            m_axis_tvalid <= inside_c;
            m_axis_tuser  <= out_user_c;
            m_axis_tlast  <= out_last_c;
            err_sof       <= err_sof_c;
            err_line      <= err_line_c;
            frame_done    <= frame_done_c;
        end
    end

endmodule

// File: tb/tb_img_axis_crop.sv
// Directed bench for img_axis_crop on an 8x4 image; every output cycle is checked
// against hand-specified inside columns and error positions.
module tb_img_axis_crop;

    logic        clk;
    logic        rst_n;
    logic [9:0]  s_tdata;
    logic        s_tvalid, s_tuser, s_tlast;
    logic [11:0] x_start, y_start, crop_w, crop_h;
    logic [9:0]  m_tdata;
    logic        m_tvalid, m_tuser, m_tlast;
    logic        err_sof, err_line, frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [9:0]  exp_td = '0;
    logic        gaps = 1'b0;
    string       phase = "reset";

    img_axis_crop #(
        .DATA_WIDTH(10), .IMG_WIDTH(8), .IMG_HEIGHT(4), .CW(12)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .x_start       (x_start),
        .y_start       (y_start),
        .crop_w        (crop_w),
        .crop_h        (crop_h),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .err_sof       (err_sof),
        .err_line      (err_line),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic chk_all(input logic ev, eu, el, ees, eel, efd);
        chk("tvalid", 32'(m_tvalid), 32'(ev));
        chk("tuser", 32'(m_tuser), 32'(eu));
        chk("tlast", 32'(m_tlast), 32'(el));
        chk("err_sof", 32'(err_sof), 32'(ees));
        chk("err_line", 32'(err_line), 32'(eel));
        chk("frame_done", 32'(frame_done), 32'(efd));
        chk("tdata", 32'(m_tdata), 32'(exp_td));
    endtask

    // Drive one cycle at the falling edge, check its registered response one cycle later
    task automatic cyc(input logic v, u, l, input logic [9:0] d,
                       input logic ev, eu, el, ees, eel, efd);
        s_tvalid = v;
        s_tuser  = u;
        s_tlast  = l;
        s_tdata  = d;
        @(negedge clk);
        if (ev) exp_td = d;
        chk_all(ev, eu, el, ees, eel, efd);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 10'($urandom_range(0, 1023)), 0, 0, 0, 0, 0, 0);
    endtask

    // Beats c0..c1 of row r (data = r*8+c); expected output on columns ilo..ihi
    task automatic send_row(input int r, input int c0, input int c1,
                            input logic u0, input logic l1, input int elc,
                            input logic es0, input logic fd1,
                            input int ilo, input int ihi, input logic iu);
        for (int c = c0; c <= c1; c++) begin
            logic ins;
            if (gaps && ($urandom_range(0, 1) == 1)) idle();
            ins = (c >= ilo) && (c <= ihi);
            cyc(1'b1, u0 && (c == c0), l1 && (c == c1), 10'(r * 8 + c),
                ins, ins && iu && (c == ilo), ins && (c == ihi),
                es0 && (c == c0), c == elc, fd1 && (c == c1));
        end
    endtask

    task automatic set_win(input int x, input int y, input int w, input int h);
        x_start = 12'(x);
        y_start = 12'(y);
        crop_w  = 12'(w);
        crop_h  = 12'(h);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        set_win(2, 1, 3, 2);
        repeat (2) @(negedge clk);
        chk_all(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle();

        phase = "frame_a";
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 2, 4, 1);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 2, 4, 0);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 99, -1, 0);
        idle();

        phase = "gaps";
        gaps = 1'b1;
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        set_win(0, 0, 8, 4);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 2, 4, 1);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 2, 4, 0);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 99, -1, 0);
        gaps = 1'b0;
        idle();

        phase = "clip";
        set_win(6, 2, 5, 5);
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 6, 7, 1);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 6, 7, 0);

        phase = "line_err";
        set_win(2, 1, 3, 2);
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        send_row(1, 0, 5, 0, 1, 5, 0, 0, 2, 4, 1);
        send_row(2, 0, 7, 0, 0, 7, 0, 0, 2, 4, 0);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 99, -1, 0);

        phase = "sof_err";
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 2, 4, 1);
        send_row(2, 0, 2, 0, 0, -1, 0, 0, 2, 4, 0);
        set_win(6, 2, 5, 5);
        send_row(0, 0, 7, 1, 1, -1, 1, 0, 99, -1, 0);
        set_win(2, 1, 3, 2);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 6, 7, 1);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 6, 7, 0);

        phase = "reset_mid";
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 99, -1, 0);
        send_row(1, 0, 3, 0, 0, -1, 0, 0, 2, 4, 1);
        s_tvalid = 1'b0;
        rst_n    = 1'b0;
        #1;
        exp_td = '0;
        chk_all(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_row(1, 4, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        set_win(0, 0, 2, 1);
        send_row(0, 0, 7, 1, 1, -1, 0, 0, 0, 1, 1);
        set_win(2, 1, 3, 2);
        send_row(1, 0, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        send_row(2, 0, 7, 0, 1, -1, 0, 0, 99, -1, 0);
        send_row(3, 0, 7, 0, 1, -1, 0, 1, 99, -1, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
